// File: rtl/bus_req_parser.sv
// Turns an ASCII hex message stream ('R'AAAA<eol> or 'W'AAAADDDD<eol>) into
// single bus requests with a valid/ready output register holding one request.
module bus_req_parser #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [7:0]            rx_data_i,
    input  logic                  rx_valid_i,
    output logic [ADDR_WIDTH-1:0] req_addr_o,
    output logic [DATA_WIDTH-1:0] req_data_o,
    output logic                  req_rw_o,
    output logic                  req_valid_o,
    input  logic                  req_ready_i,
    output logic                  err_o,
    output logic                  overflow_o
);

    localparam int ADDR_NIBS = ADDR_WIDTH / 4;
    localparam int DATA_NIBS = DATA_WIDTH / 4;

    typedef enum logic [1:0] {IDLE, ADDR, DATA, TERM} state_t;

    state_t                  state_reg;
    logic [3:0]              cnt_reg;
    logic [ADDR_WIDTH-1:0]   addr_sh_reg;
    logic [DATA_WIDTH-1:0]   data_sh_reg;
    logic                    rw_sh_reg;
    logic [ADDR_WIDTH-1:0]   req_addr_reg;
    logic [DATA_WIDTH-1:0]   req_data_reg;
    logic                    req_rw_reg;
    logic                    req_valid_reg;
    logic                    err_reg;
    logic                    overflow_reg;

    logic       is_hex;
    logic       is_term;
    logic       is_rw;
    logic [3:0] nib;

    always_comb begin
        is_hex  = 1'b0;
        nib     = 4'd0;
        is_term = (rx_data_i == 8'h0D) || (rx_data_i == 8'h0A);
        is_rw   = (rx_data_i == 8'h52) || (rx_data_i == 8'h57);
        if (rx_data_i >= 8'h30 && rx_data_i <= 8'h39) begin
            is_hex = 1'b1;
            nib    = rx_data_i[3:0];
        end else if ((rx_data_i >= 8'h41 && rx_data_i <= 8'h46) ||
                     (rx_data_i >= 8'h61 && rx_data_i <= 8'h66)) begin
            is_hex = 1'b1;
            nib    = rx_data_i[3:0] + 4'd9;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            cnt_reg       <= 4'd0;
            addr_sh_reg   <= '0;
            data_sh_reg   <= '0;
            rw_sh_reg     <= 1'b0;
            req_addr_reg  <= '0;
            req_data_reg  <= '0;
            req_rw_reg    <= 1'b0;
            req_valid_reg <= 1'b0;
            err_reg       <= 1'b0;
            overflow_reg  <= 1'b0;
        end else begin
            err_reg      <= 1'b0;
            overflow_reg <= 1'b0;
            if (req_valid_reg && req_ready_i)
                req_valid_reg <= 1'b0;

            if (rx_valid_i) begin
                // 'R'/'W' always (re)starts a message; mid-message it also flags an error
                if (is_rw) begin
                    err_reg     <= (state_reg != IDLE);
                    state_reg   <= ADDR;
                    rw_sh_reg   <= rx_data_i[2];
                    addr_sh_reg <= '0;
                    data_sh_reg <= '0;
                    cnt_reg     <= 4'd0;
                end else begin
                    case (state_reg)
                        IDLE: begin
                            if (!is_term)
                                err_reg <= 1'b1;
                        end
                        ADDR: begin
                            if (is_hex) begin
                                addr_sh_reg <= {addr_sh_reg[ADDR_WIDTH-5:0], nib};
                                if (cnt_reg == 4'(ADDR_NIBS - 1)) begin
                                    cnt_reg   <= 4'd0;
                                    state_reg <= rw_sh_reg ? DATA : TERM;
                                end else begin
                                    cnt_reg <= cnt_reg + 4'd1;
                                end
                            end else begin
                                err_reg   <= 1'b1;
                                state_reg <= IDLE;
                            end
                        end
                        DATA: begin
                            if (is_hex) begin
                                data_sh_reg <= {data_sh_reg[DATA_WIDTH-5:0], nib};
                                if (cnt_reg == 4'(DATA_NIBS - 1)) begin
                                    cnt_reg   <= 4'd0;
                                    state_reg <= TERM;
                                end else begin
                                    cnt_reg <= cnt_reg + 4'd1;
                                end
                            end else begin
                                err_reg   <= 1'b1;
                                state_reg <= IDLE;
                            end
                        end
                        TERM: begin
                            state_reg <= IDLE;
                            if (is_term) begin
                                // Accept if the slot is empty or is being emptied this same edge
                                if (!req_valid_reg || req_ready_i) begin
                                    req_addr_reg  <= addr_sh_reg;
                                    req_data_reg  <= rw_sh_reg ? data_sh_reg : '0;
                                    req_rw_reg    <= rw_sh_reg;
                                    req_valid_reg <= 1'b1;
                                end else begin
                                    overflow_reg <= 1'b1;
                                end
                            end else begin
                                err_reg <= 1'b1;
                            end
                        end
                        default: state_reg <= IDLE;
                    endcase
                end
            end
        end
    end

    assign req_addr_o  = req_addr_reg;
    assign req_data_o  = req_data_reg;
    assign req_rw_o    = req_rw_reg;
    assign req_valid_o = req_valid_reg;
    assign err_o       = err_reg;
    assign overflow_o  = overflow_reg;

endmodule

// File: tb/tb_bus_req_parser.sv
// Table-driven check of bus_req_parser: one vector per clock, outputs compared
// just after each rising edge, plus a hand sequence for reset with a pending request.
module tb_bus_req_parser;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  rx_data_i;
    logic        rx_valid_i;
    logic [15:0] req_addr_o;
    logic [15:0] req_data_o;
    logic        req_rw_o;
    logic        req_valid_o;
    logic        req_ready_i;
    logic        err_o;
    logic        overflow_o;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    bus_req_parser #(.ADDR_WIDTH(16), .DATA_WIDTH(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .rx_data_i  (rx_data_i),
        .rx_valid_i (rx_valid_i),
        .req_addr_o (req_addr_o),
        .req_data_o (req_data_o),
        .req_rw_o   (req_rw_o),
        .req_valid_o(req_valid_o),
        .req_ready_i(req_ready_i),
        .err_o      (err_o),
        .overflow_o (overflow_o)
    );

    typedef struct {
        logic        rst;
        logic        vld;
        logic [7:0]  data;
        logic        rdy;
        logic        ev;
        logic [15:0] ea;
        logic [15:0] ed;
        logic        erw;
        logic        ee;
        logic        eo;
    } vec_t;

    vec_t vecs[$];

    task automatic q(input logic r, input logic v, input logic [7:0] d, input logic rdy,
                     input logic ev, input logic [15:0] ea, input logic [15:0] ed,
                     input logic erw, input logic ee, input logic eo);
        vec_t t;
        t.rst = r; t.vld = v; t.data = d; t.rdy = rdy;
        t.ev = ev; t.ea = ea; t.ed = ed; t.erw = erw; t.ee = ee; t.eo = eo;
        vecs.push_back(t);
    endtask

    // Push legal bytes that produce no event; ev/ea describe a read held in the output slot
    task automatic qs(input string s, input logic rdy, input logic ev, input logic [15:0] ea);
        for (int i = 0; i < s.len(); i++)
            q(1'b0, 1'b1, 8'(s[i]), rdy, ev, ea, 16'h0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic check(input string name, input vec_t t);
        logic ok;
        total++;
        ok = (req_valid_o === t.ev) && (err_o === t.ee) && (overflow_o === t.eo);
        if (t.ev)
            ok = ok && (req_addr_o === t.ea) && (req_data_o === t.ed) && (req_rw_o === t.erw);
        if (!ok) begin
            bad++;
            $display("FAIL %s: got v=%b a=%h d=%h rw=%b e=%b o=%b, need v=%b a=%h d=%h rw=%b e=%b o=%b",
                     name, req_valid_o, req_addr_o, req_data_o, req_rw_o, err_o, overflow_o,
                     t.ev, t.ea, t.ed, t.erw, t.ee, t.eo);
        end else if (t.ev || t.ee || t.eo) begin
            $display("%s: v=%b a=%h d=%h rw=%b e=%b o=%b", name, req_valid_o, req_addr_o,
                     req_data_o, req_rw_o, err_o, overflow_o);
        end
    endtask

    task automatic send(input logic [7:0] b, input logic rdy);
        rx_data_i   = b;
        rx_valid_i  = 1'b1;
        req_ready_i = rdy;
        @(posedge clk);
        #1;
        rx_valid_i = 1'b0;
    endtask

    initial begin
        vec_t   z;
        string  s;
        logic   seen;
        rst = 1'b0; rx_data_i = 8'h00; rx_valid_i = 1'b0; req_ready_i = 1'b0;

        // reset
        q(1, 0, 8'h00, 0, 0, 16'h0, 16'h0, 0, 0, 0);
        // read, ready high
        qs("R1234", 1, 0, 16'h0);
        q(0, 1, 8'h0D, 1, 1, 16'h1234, 16'h0, 0, 0, 0);
        q(0, 0, 8'h00, 1, 0, 16'h0, 16'h0, 0, 0, 0);
        // write with lowercase hex and a stall
        qs("Wbeef00A5", 0, 0, 16'h0);
        q(0, 1, 8'h0A, 0, 1, 16'hBEEF, 16'h00A5, 1, 0, 0);
        for (int i = 0; i < 4; i++)
            q(0, 0, 8'h00, 0, 1, 16'hBEEF, 16'h00A5, 1, 0, 0);
        q(0, 0, 8'h00, 1, 0, 16'h0, 16'h0, 0, 0, 0);
        // malformed: 'G' aborts, '4' is then garbage in IDLE, CR ignored
        qs("R12", 1, 0, 16'h0);
        q(0, 1, "G", 1, 0, 16'h0, 16'h0, 0, 1, 0);
        q(0, 1, "4", 1, 0, 16'h0, 16'h0, 0, 1, 0);
        q(0, 1, 8'h0D, 1, 0, 16'h0, 16'h0, 0, 0, 0);
        qs("R0001", 1, 0, 16'h0);
        q(0, 1, 8'h0D, 1, 1, 16'h0001, 16'h0, 0, 0, 0);
        q(0, 0, 8'h00, 1, 0, 16'h0, 16'h0, 0, 0, 0);
        // blank lines then resync on 'R' mid-write
        q(0, 1, 8'h0D, 1, 0, 16'h0, 16'h0, 0, 0, 0);
        q(0, 1, 8'h0A, 1, 0, 16'h0, 16'h0, 0, 0, 0);
        qs("W12", 1, 0, 16'h0);
        q(0, 1, "R", 1, 0, 16'h0, 16'h0, 0, 1, 0);
        qs("00FF", 1, 0, 16'h0);
        q(0, 1, 8'h0D, 1, 1, 16'h00FF, 16'h0, 0, 0, 0);
        q(0, 0, 8'h00, 1, 0, 16'h0, 16'h0, 0, 0, 0);
        // non-terminator where the terminator belongs
        qs("R1234", 1, 0, 16'h0);
        q(0, 1, "5", 1, 0, 16'h0, 16'h0, 0, 1, 0);
        q(0, 0, 8'h00, 1, 0, 16'h0, 16'h0, 0, 0, 0);
        // overflow, then completion coinciding with handshake
        qs("R0010", 0, 0, 16'h0);
        q(0, 1, 8'h0D, 0, 1, 16'h0010, 16'h0, 0, 0, 0);
        qs("R0020", 0, 1, 16'h0010);
        q(0, 1, 8'h0D, 0, 1, 16'h0010, 16'h0, 0, 0, 1);
        qs("R0030", 0, 1, 16'h0010);
        q(0, 1, 8'h0D, 1, 1, 16'h0030, 16'h0, 0, 0, 0);
        q(0, 0, 8'h00, 1, 0, 16'h0, 16'h0, 0, 0, 0);
        // reset mid-message: following digits are garbage in IDLE
        qs("W1234", 1, 0, 16'h0);
        q(1, 0, 8'h00, 1, 0, 16'h0, 16'h0, 0, 0, 0);
        s = "56789";
        for (int i = 0; i < s.len(); i++)
            q(0, 1, 8'(s[i]), 1, 0, 16'h0, 16'h0, 0, 1, 0);
        q(0, 1, 8'h0D, 1, 0, 16'h0, 16'h0, 0, 0, 0);
        q(0, 0, 8'h00, 1, 0, 16'h0, 16'h0, 0, 0, 0);

        @(posedge clk);
        #1;
        for (int i = 0; i < vecs.size(); i++) begin
            rst         = vecs[i].rst;
            rx_valid_i  = vecs[i].vld;
            rx_data_i   = vecs[i].data;
            req_ready_i = vecs[i].rdy;
            @(posedge clk);
            #1;
            check($sformatf("vec%0d byte=%h", i, vecs[i].data), vecs[i]);
        end
        rst = 1'b0; rx_valid_i = 1'b0; req_ready_i = 1'b0;

        // pending request discarded by reset
        s = "R0042";
        for (int i = 0; i < s.len(); i++)
            send(8'(s[i]), 1'b0);
        send(8'h0D, 1'b0);
        seen = 1'b0;
        for (int c = 0; c < 4 && !seen; c++) begin
            if (req_valid_o === 1'b1) seen = 1'b1;
            else begin @(posedge clk); #1; end
        end
        z.rst = 0; z.vld = 0; z.data = 0; z.rdy = 0;
        z.ev = 1; z.ea = 16'h0042; z.ed = 16'h0; z.erw = 0; z.ee = 0; z.eo = 0;
        check("pending_before_rst", z);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        z.ev = 0;
        check("pending_after_rst", z);
        @(posedge clk);
        #1;
        check("idle_after_rst", z);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/bus_req_parser.md
Name: bus_req_parser

Overview:
- Upstream stage of the memory-mapped bus chain.
- Consumes a received byte stream (one byte per strobe) carrying ASCII hex request messages.
- Converts each complete message into a single bus request (addr/data/rw with valid/ready handshake).
- Its request port drives the first core on the chain (e.g. the LUT RAM core).
- Holds one pending request; malformed or overrun messages are dropped and flagged.

Parameters:
ADDR_WIDTH, 16, bus address width; exactly 4 hex digits in the message.
DATA_WIDTH, 16, bus data width; exactly 4 hex digits in write messages.

Ports:
clk  input  1  system clock; all logic on rising edge.
rst  input  1  synchronous, active-high reset.
rx_data_i  input  8  received byte.
rx_valid_i  input  1  one-cycle strobe; rx_data_i valid this cycle; no backpressure.
req_addr_o  output  ADDR_WIDTH  request address.
req_data_o  output  DATA_WIDTH  write data (0 for reads).
req_rw_o  output  1  1 = write, 0 = read.
req_valid_o  output  1  request pending.
req_ready_i  input  1  downstream accepts when req_valid_o && req_ready_i.
err_o  output  1  one-cycle pulse: malformed message discarded.
overflow_o  output  1  one-cycle pulse: complete message dropped because a request was still pending.

Behaviour:
- Reset (rst=1 at an edge): state=IDLE, nibble count=0; req_addr_o, req_data_o, req_rw_o, req_valid_o, err_o, overflow_o all 0. Applies mid-message and with a request pending; the pending request is discarded.
- Message grammar: 'R' A A A A T (read) or 'W' A A A A D D D D T (write).
  - A/D are hex digits 0-9, A-F, a-f, most significant nibble first.
  - T is CR (0x0D) or LF (0x0A).
- Bytes only advance the FSM on cycles with rx_valid_i=1.
- FSM states:
  - IDLE: 'R'/'W' -> ADDR, latch rw, clear shift registers and nibble count. CR/LF -> IDLE silently (blank lines ignored). Any other byte -> IDLE with err_o pulse.
  - ADDR: hex -> shift nibble into addr, count++. After the 4th nibble: go to DATA for a write, TERM for a read.
  - DATA: hex -> shift into data. After the 4th nibble -> TERM.
  - TERM: CR/LF -> message complete, then IDLE.
  - Error rule in ADDR/DATA/TERM: any byte not legal for the state aborts to IDLE with an err_o pulse.
  - Exception: 'R'/'W' in ADDR/DATA/TERM pulses err_o and immediately starts a new message, going to ADDR exactly as from IDLE (resync).
- Completion and output register:
  - On the completing edge, if req_valid_o=0, or req_valid_o && req_ready_i in that same cycle: load addr/data/rw, assert req_valid_o.
  - req_valid_o is visible the cycle after the terminator strobe (latency 1).
  - Otherwise the message is dropped, overflow_o pulses, and the outputs are unchanged.
- Handshake:
  - req_valid_o stays high and addr/data/rw stay stable until the handshake edge.
  - On handshake with no new completion, req_valid_o -> 0 at that edge.
  - Reads always present req_data_o=0.
- err_o and overflow_o are registered, high exactly one cycle per event, and never both for the same byte.
- Parsing continues while a request is pending (no input stall).

Test Plan:
- Read: rst, then "R1234\r" with req_ready_i=1 -> one cycle after '\r' strobe: req_valid_o=1, addr=0x1234, rw=0, data=0; low the next cycle.
- Write with stall: "Wbeef00A5\n", req_ready_i=0 for 5 cycles then 1 -> addr=0xBEEF, data=0x00A5, rw=1; stable and valid through the stall; drops after the handshake edge.
- Malformed: "R12G4\r" -> err_o pulse on the 'G' strobe cycle, no request. A following "R0001\r" -> request addr=0x0001.
- Resync and blank lines: "\r\nW12R00FF\r" -> no err for the CR/LF; err_o on the second 'R'; single read addr=0x00FF.
- Overflow: "R0010\r" then "R0020\r" with req_ready_i=0 throughout -> addr stays 0x0010, overflow_o pulses once on the second terminator. Then ready=1, "R0030\r" terminator coinciding with the handshake -> back-to-back valid with addr=0x0030.
- Reset mid-operation: "W1234" then rst=1 for 1 cycle, then "56789\r" -> err_o on '5' (IDLE), no request. Pending request at rst -> req_valid_o=0 next cycle.
